mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single-ported main RAM between two requesters: instruction fetch (port F, read-only) and load/store (port D, read/write).
- Sits between the control unit's fetch/ld/st sequencing and the RAM, and replaces the direct mem_read/mem_write/MAR drive.
- Serialises accesses through a small FSM, handles configurable RAM read latency, and returns one done pulse per transaction.

Parameters:
ADDR_W, 9, RAM word-address width (512 words)
DATA_W, 32, data width
MEM_LATENCY, 1, cycles from mem_read assertion to valid mem_rdata; legal range 1..4

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
f_req  in  1  fetch request; held with f_addr until f_done
f_addr  in  ADDR_W  fetch address
f_gnt  out  1  one-cycle pulse: fetch request accepted
f_done  out  1  one-cycle pulse: fetch data valid on rdata
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_done
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_gnt  out  1  one-cycle pulse: data request accepted
d_done  out  1  one-cycle pulse: data access complete
rdata  out  DATA_W  registered read data, shared by both ports
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_read  out  1  RAM read strobe
mem_write  out  1  RAM write strobe
mem_rdata  in  DATA_W  RAM read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Latched owner = F, last_grant = F.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Arbitrates only in this state. A pending request is req=1.
  - On grant, in the same cycle (t):
    - Pulse x_gnt.
    - Latch owner, addr, we (forced 0 for F) and wdata.
    - Load lat_cnt = MEM_LATENCY.
    - Go to ACCESS.
- Priority: fixed, D over F. Both pending in the same cycle: D granted, F waits in IDLE.
- ACCESS, read:
  - mem_read=1 and mem_addr=latched addr for MEM_LATENCY cycles (t+1..t+L).
  - lat_cnt decrements each cycle.
  - When lat_cnt=1: rdata <= mem_rdata, then go to DONE.
- ACCESS, write:
  - mem_write=1 for exactly one cycle (t+1), with mem_addr and mem_wdata = latched values.
  - Then go to DONE. lat_cnt is ignored.
- DONE:
  - Pulse owner's x_done: cycle t+L+1 for a read, t+2 for a write.
  - Next state IDLE unconditionally.
  - A request still held is re-arbitrated in IDLE as a new transaction.
- Throughput: one access per L+2 cycles (read) or 3 cycles (write).
- rdata updates only when a read completes; it holds its value across writes and idle time.
- mem_addr and mem_wdata are 0 outside ACCESS. mem_read and mem_write are never high together.
- Request inputs are ignored after grant. A requester dropping req mid-transaction does not abort it: a write is still performed and x_done still pulses.
- Reset asserted mid-transaction:
  - Asynchronous return to IDLE; mem_read and mem_write drop immediately.
  - No gnt or done is issued; rdata clears to 0.
- busy=1 in ACCESS and DONE.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin arbitration.
  - When both F and D are pending in IDLE, grant the port opposite to last_grant.
  - A single pending port is always granted.
  - last_grant updates on every grant.
- Undefined: fixed D-over-F priority. last_grant register is absent.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ACCESS, DONE);
  - port-id constants PORT_F=0, PORT_D=1;
  - default widths ADDR_W_DEF=9, DATA_W_DEF=32.
- One sub-module, mem_arb_pick: combinational grant selection.
  - Inputs: f_req, d_req, last_grant.
  - Outputs: grant_valid, grant_id.
  - Contains both the fixed-priority and round-robin variants under the macro.

Test Plan:
1. Reset held 3 cycles, then released with no requests -> all outputs 0, busy=0 throughout.
2. L=1, f_req with f_addr=0x010, RAM returns 0xDEADBEEF -> f_gnt @t, mem_read=1 with mem_addr=0x010 @t+1, f_done and rdata=0xDEADBEEF @t+2.
3. d_req, d_we=1, d_addr=0x1F0, d_wdata=0x12345678 -> d_gnt @t, mem_write=1 for one cycle @t+1, d_done @t+2, rdata unchanged.
4. L=3, d_req read at 0x005 -> mem_read high @t+1..t+3, d_done @t+4, back in IDLE @t+5.
5. f_req and d_req both held continuously, L=1:
   - Macro undefined: grants D,D,D…; F is never granted while D is held.
   - Macro defined: grants D,F,D,F with done pulses alternating.
6. Reset asserted @t+1 of an L=3 read -> mem_read drops in the same cycle, no done, rdata=0; a request after release is serviced normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the main-RAM port arbiter: FSM state encoding,
//   requester identifiers and default bus widths.
//   Optional build macro used by the importing modules: MEM_ARB_RR_EN.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_e;

   localparam logic PORT_F = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam int ADDR_W_DEF = 9;
   localparam int DATA_W_DEF = 32;

   // wide enough for a latency of up to 4 cycles
   localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational grant selection between the fetch (F) and load/store (D)
//   requesters.
//   Build macro MEM_ARB_RR_EN:
//     defined   - round-robin: on contention the port opposite to last_grant
//                 wins; a lone requester always wins.
//     undefined - fixed priority, D over F; last_grant is not used.
// Ports:
//   f_req, d_req  in   pending requests
//   last_grant    in   port granted most recently
//   grant_valid   out  at least one request pending
//   grant_id      out  winning port (PORT_F / PORT_D)
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic f_req,
   input  logic d_req,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_id
);

   assign grant_valid = f_req | d_req;

`ifdef MEM_ARB_RR_EN
   always_comb begin
      if (f_req && d_req) begin
         grant_id = (last_grant == PORT_D) ? PORT_F : PORT_D;
      end else begin
         grant_id = d_req ? PORT_D : PORT_F;
      end
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   assign grant_id          = d_req ? PORT_D : PORT_F;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-ported main RAM between instruction fetch (F, read
//   only) and load/store (D, read/write). One access at a time; each
//   accepted request gets a gnt pulse when accepted and a done pulse when
//   complete. Reads hold mem_read for MEM_LATENCY cycles and capture
//   mem_rdata on the last one; writes strobe mem_write for one cycle.
//   Build macro MEM_ARB_RR_EN selects round-robin arbitration (default:
//   fixed D-over-F priority).
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   f_req/f_addr            fetch request, held until f_done
//   f_gnt/f_done            fetch accepted / fetch data valid on rdata
//   d_req/d_we/d_addr/d_wdata  data request, held until d_done
//   d_gnt/d_done            data accepted / data access complete
//   rdata                   last read result, shared by both ports
//   mem_addr/mem_wdata/mem_read/mem_write/mem_rdata  RAM interface
//   busy                    transaction in progress
//
// state  | meaning
// IDLE   | arbitrate; grant latches the request and starts the access
// ACCESS | drive the RAM: one write cycle or MEM_LATENCY read cycles
// DONE   | pulse the owner's done, then back to IDLE
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int MEM_LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_done,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   arb_state_e           state_q, state_d;
   logic                 owner_q;
   logic [ADDR_W-1:0]    addr_q;
   logic                 we_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [LAT_CNT_W-1:0] lat_cnt_q;
   logic [DATA_W-1:0]    rdata_q;

   logic last_grant;
   logic grant_valid;
   logic grant_id;
   logic take;
   logic last_rd;

`ifdef MEM_ARB_RR_EN
   logic last_grant_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_grant_q <= PORT_F;
      end else if (take) begin
         last_grant_q <= grant_id;
      end
   end

   assign last_grant = last_grant_q;
`else
   assign last_grant = PORT_F;
`endif

   mem_arb_pick u_pick (
      .f_req       (f_req),
      .d_req       (d_req),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign take    = (state_q == IDLE) && grant_valid;
   assign last_rd = (state_q == ACCESS) && !we_q && (lat_cnt_q == LAT_CNT_W'(1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_valid) state_d = ACCESS;
         ACCESS:  if (we_q || last_rd) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request inputs are sampled only at grant; later changes are ignored.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         owner_q   <= PORT_F;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         lat_cnt_q <= '0;
         rdata_q   <= '0;
      end else begin
         if (take) begin
            owner_q   <= grant_id;
            addr_q    <= (grant_id == PORT_D) ? d_addr : f_addr;
            we_q      <= (grant_id == PORT_D) && d_we;
            wdata_q   <= d_wdata;
            lat_cnt_q <= LAT_CNT_W'(MEM_LATENCY);
         end else if ((state_q == ACCESS) && !we_q) begin
            lat_cnt_q <= lat_cnt_q - LAT_CNT_W'(1);
         end
         if (last_rd) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   // gnt is gated with reset so a request held during reset is not
   // acknowledged before the arbiter is actually running.
   always_comb begin
      f_gnt     = 1'b0;
      d_gnt     = 1'b0;
      f_done    = 1'b0;
      d_done    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_valid && !reset) begin
               f_gnt = (grant_id == PORT_F);
               d_gnt = (grant_id == PORT_D);
            end
         end
         ACCESS: begin
            mem_addr  = addr_q;
            mem_read  = !we_q;
            mem_write = we_q;
            // write data only appears on the bus for an actual write
            mem_wdata = we_q ? wdata_q : '0;
         end
         DONE: begin
            f_done = (owner_q == PORT_F);
            d_done = (owner_q == PORT_D);
         end
         default: ;
      endcase
   end

   assign busy  = (state_q != IDLE);
   assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int TMO = 3000;

   typedef struct {
      logic       port;
      int         done_cyc;
      logic       we;
      logic [31:0] rd;
   } exp_t;

   logic clock = 1'b0;
   logic reset;

   logic        f_req   [2];
   logic [8:0]  f_addr  [2];
   logic        f_gnt   [2];
   logic        f_done  [2];
   logic        d_req   [2];
   logic        d_we    [2];
   logic [8:0]  d_addr  [2];
   logic [31:0] d_wdata [2];
   logic        d_gnt   [2];
   logic        d_done  [2];
   logic [31:0] rdata   [2];
   logic [8:0]  mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic        mem_read  [2];
   logic        mem_write [2];
   logic [31:0] mem_rdata [2];
   logic        busy      [2];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LATENCY(1)) u_dut_l1 (
      .clock(clock), .reset(reset),
      .f_req(f_req[0]), .f_addr(f_addr[0]), .f_gnt(f_gnt[0]), .f_done(f_done[0]),
      .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
      .d_gnt(d_gnt[0]), .d_done(d_done[0]), .rdata(rdata[0]),
      .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_read(mem_read[0]),
      .mem_write(mem_write[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
   );

   mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LATENCY(3)) u_dut_l3 (
      .clock(clock), .reset(reset),
      .f_req(f_req[1]), .f_addr(f_addr[1]), .f_gnt(f_gnt[1]), .f_done(f_done[1]),
      .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
      .d_gnt(d_gnt[1]), .d_done(d_done[1]), .rdata(rdata[1]),
      .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_read(mem_read[1]),
      .mem_write(mem_write[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
   );

   function automatic logic [31:0] init_val(input logic [8:0] a);
      return {a, 7'h55, ~a, 7'h2A};
   endfunction

   function automatic void chk(input int i, input string nm,
                               input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL inst%0d %s got=%0h exp=%0h t=%0t", i, nm, act, exp, $time);
      end
   endfunction

   function automatic void tmo(input int i, input string nm);
      checks++;
      errors++;
      $display("FAIL inst%0d %s got=no pulse exp=pulse within %0d cycles t=%0t",
               i, nm, TMO, $time);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int L = (g == 0) ? 1 : 3;

      // RAM: data is only presented once mem_read has been high L cycles
      logic [31:0] ram [512];
      int          rd_cnt;
      logic [31:0] junk;

      always @(posedge clock) begin
         if (reset) begin
            for (int a = 0; a < 512; a++) ram[a] <= init_val(9'(a));
            rd_cnt <= 0;
         end else begin
            if (mem_write[g]) ram[mem_addr[g]] <= mem_wdata[g];
            rd_cnt <= mem_read[g] ? rd_cnt + 1 : 0;
         end
         junk <= $urandom;
      end

      assign mem_rdata[g] = (mem_read[g] && (rd_cnt + 1 >= L)) ? ram[mem_addr[g]] : junk;

      // transaction-level reference: timeline of the current access
      int          cyc = 0;
      int          free_cyc, cur_start, cur_done;
      bit          cur_v;
      logic        cur_we, cur_port;
      logic [8:0]  cur_addr;
      logic [31:0] cur_wdata, cur_rd, exp_rdata;
      logic [31:0] ref_mem [512];
      exp_t        q [$];
`ifdef MEM_ARB_RR_EN
      logic        last_g;
`endif

      always @(negedge clock) begin
         logic       e_rd, e_wr, e_busy, win;
         logic [1:0] e_done, e_gnt;
         exp_t       e;
         cyc++;
         if (reset) begin
            chk(g, "rst_gnt",  64'({d_gnt[g], f_gnt[g]}), 64'(0));
            chk(g, "rst_done", 64'({d_done[g], f_done[g]}), 64'(0));
            chk(g, "rst_mem_rw", 64'({mem_read[g], mem_write[g]}), 64'(0));
            chk(g, "rst_mem_addr", 64'(mem_addr[g]), 64'(0));
            chk(g, "rst_mem_wdata", 64'(mem_wdata[g]), 64'(0));
            chk(g, "rst_busy", 64'(busy[g]), 64'(0));
            chk(g, "rst_rdata", 64'(rdata[g]), 64'(0));
            cur_v     = 1'b0;
            free_cyc  = 0;
            exp_rdata = '0;
            q.delete();
            for (int a = 0; a < 512; a++) ref_mem[a] = init_val(9'(a));
`ifdef MEM_ARB_RR_EN
            last_g = 1'b0;
`endif
         end else begin
            e_rd   = cur_v && !cur_we && (cyc >= cur_start + 1) && (cyc <= cur_start + L);
            e_wr   = cur_v && cur_we && (cyc == cur_start + 1);
            e_busy = cur_v && (cyc > cur_start) && (cyc <= cur_done);
            e_done = (cur_v && cyc == cur_done) ? (cur_port ? 2'b10 : 2'b01) : 2'b00;
            if (cur_v && cyc == cur_done && !cur_we) exp_rdata = cur_rd;

            chk(g, "mem_read",  64'(mem_read[g]), 64'(e_rd));
            chk(g, "mem_write", 64'(mem_write[g]), 64'(e_wr));
            chk(g, "mem_addr",  64'(mem_addr[g]), 64'((e_rd || e_wr) ? cur_addr : 9'd0));
            chk(g, "mem_wdata", 64'(mem_wdata[g]), 64'(e_wr ? cur_wdata : 32'd0));
            chk(g, "busy",      64'(busy[g]), 64'(e_busy));
            chk(g, "done_timing", 64'({d_done[g], f_done[g]}), 64'(e_done));
            chk(g, "rdata",     64'(rdata[g]), 64'(exp_rdata));

            if (f_done[g] || d_done[g]) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL inst%0d done_unexpected got=done exp=none t=%0t", g, $time);
               end else begin
                  e = q.pop_front();
                  chk(g, "sb_done_port", 64'({d_done[g], f_done[g]}), 64'(e.port ? 2'b10 : 2'b01));
                  chk(g, "sb_done_cycle", 64'(cyc), 64'(e.done_cyc));
                  if (!e.we) chk(g, "sb_read_data", 64'(rdata[g]), 64'(e.rd));
               end
            end
            if (cur_v && cyc == cur_done) cur_v = 1'b0;

            e_gnt = 2'b00;
            if (cyc >= free_cyc && (f_req[g] || d_req[g])) begin
`ifdef MEM_ARB_RR_EN
               if (f_req[g] && d_req[g]) win = ~last_g;
               else                      win = d_req[g];
               last_g = win;
`else
               win = d_req[g];
`endif
               e_gnt     = win ? 2'b10 : 2'b01;
               cur_v     = 1'b1;
               cur_port  = win;
               cur_start = cyc;
               cur_we    = win && d_we[g];
               cur_addr  = win ? d_addr[g] : f_addr[g];
               cur_wdata = d_wdata[g];
               cur_rd    = ref_mem[cur_addr];
               if (cur_we) ref_mem[cur_addr] = cur_wdata;
               cur_done  = cyc + (cur_we ? 2 : L + 1);
               free_cyc  = cur_done + 1;
               e.port     = win;
               e.done_cyc = cur_done;
               e.we       = cur_we;
               e.rd       = cur_rd;
               q.push_back(e);
            end
            chk(g, "gnt", 64'({d_gnt[g], f_gnt[g]}), 64'(e_gnt));
         end
      end
   end

   task automatic f_op(input int i, input logic [8:0] a, input bit drop);
      int n;
      f_addr[i] = a;
      f_req[i]  = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (!f_gnt[i] && n < TMO);
      if (!f_gnt[i]) begin tmo(i, "f_gnt_wait"); f_req[i] = 1'b0; return; end
      if (drop) begin
         @(posedge clock); #1;
         f_req[i]  = 1'b0;
         f_addr[i] = ~a;
      end
      n = 0;
      do begin @(negedge clock); n++; end while (!f_done[i] && n < TMO);
      if (!f_done[i]) tmo(i, "f_done_wait");
      @(posedge clock); #1;
      f_req[i] = 1'b0;
   endtask

   task automatic d_op(input int i, input logic we, input logic [8:0] a,
                       input logic [31:0] wd, input bit drop);
      int n;
      d_we[i]    = we;
      d_addr[i]  = a;
      d_wdata[i] = wd;
      d_req[i]   = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (!d_gnt[i] && n < TMO);
      if (!d_gnt[i]) begin tmo(i, "d_gnt_wait"); d_req[i] = 1'b0; return; end
      if (drop) begin
         @(posedge clock); #1;
         d_req[i]   = 1'b0;
         d_we[i]    = ~we;
         d_addr[i]  = ~a;
         d_wdata[i] = ~wd;
      end
      n = 0;
      do begin @(negedge clock); n++; end while (!d_done[i] && n < TMO);
      if (!d_done[i]) tmo(i, "d_done_wait");
      @(posedge clock); #1;
      d_req[i] = 1'b0;
   endtask

   function automatic logic [8:0] rnd_addr();
      return ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511))
                                         : 9'($urandom_range(0, 15));
   endfunction

   task automatic idle_gap(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic run_inst(input int i);
      d_op(i, 1'b1, 9'h1F0, 32'h1234_5678, 1'b0);
      d_op(i, 1'b1, 9'h010, 32'hDEAD_BEEF, 1'b0);
      f_op(i, 9'h010, 1'b0);
      d_op(i, 1'b0, 9'h005, 32'h0, 1'b0);
      d_op(i, 1'b0, 9'h1F0, 32'h0, 1'b1);
      f_op(i, 9'h1F0, 1'b1);
      idle_gap(2);
      // both ports held back-to-back
      fork
         repeat (6) f_op(i, rnd_addr(), 1'b0);
         repeat (6) d_op(i, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, 1'b0);
      join
      idle_gap(2);
      fork
         repeat (40) begin
            idle_gap($urandom_range(0, 3));
            f_op(i, rnd_addr(), $urandom_range(0, 3) == 0);
         end
         repeat (40) begin
            idle_gap($urandom_range(0, 3));
            d_op(i, 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                 $urandom_range(0, 3) == 0);
         end
      join
   endtask

   initial begin
      int n;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         f_req[i] = 1'b0; f_addr[i] = '0;
         d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
      end
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      idle_gap(4);

      fork
         run_inst(0);
         run_inst(1);
      join
      idle_gap(5);

      // reset in the middle of a read
      for (int i = 0; i < 2; i++) begin
         d_we[i] = 1'b0; d_addr[i] = 9'h1F0; d_req[i] = 1'b1;
      end
      n = 0;
      do begin @(negedge clock); n++; end while (!d_gnt[1] && n < TMO);
      if (!d_gnt[1]) tmo(1, "rst_test_gnt_wait");
      @(posedge clock); #1;
      reset = 1'b1;
      d_req[0] = 1'b0;
      d_req[1] = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      idle_gap(2);
      fork
         d_op(0, 1'b0, 9'h1F0, 32'h0, 1'b0);
         d_op(1, 1'b0, 9'h1F0, 32'h0, 1'b0);
      join
      fork
         f_op(0, 9'h00A, 1'b0);
         f_op(1, 9'h00A, 1'b0);
      join
      idle_gap(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog got=still running exp=finished t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
